// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Registered, multi-lane immediate-decode stage for the RISC-V front end.
// Each lane's opcode is classified into an immediate format and the
// sign-extended XLEN-bit immediate is built before the bundle is stored, so
// both the output register (OUT) and the skid register (SKID) hold fully
// decoded results. A two-entry skid buffer keeps one bundle per cycle flowing
// under back-pressure while o_ready stays a registered signal.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_flush              synchronous flush: drop OUT, SKID and any same-cycle accept
//   i_valid / o_ready    upstream handshake (o_ready registered)
//   i_lane_valid         per-lane valid mask
//   i_instr              LANES x 32-bit instructions, lane k at [32k+31:32k]
//   o_valid / i_ready    downstream handshake
//   o_lane_valid         registered lane mask
//   o_instr              registered instruction passthrough
//   o_imm_src            per-lane format code, lane k at [3k+2:3k]
//   o_imm                per-lane sign-extended immediate, lane k at [XLEN*k +: XLEN]
//   o_illegal            per-lane unrecognised opcode, valid lanes only
module imm_decode_stage #(
    parameter int LANES = 1,
    parameter int XLEN  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [LANES-1:0]        i_lane_valid,
    input  logic [LANES*32-1:0]     i_instr,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [LANES-1:0]        o_lane_valid,
    output logic [LANES*32-1:0]     o_instr,
    output logic [LANES*3-1:0]      o_imm_src,
    output logic [LANES*XLEN-1:0]   o_imm,
    output logic [LANES-1:0]        o_illegal
);

    localparam logic [2:0] SRC_NO = 3'd0;
    localparam logic [2:0] SRC_RT = 3'd1;
    localparam logic [2:0] SRC_IT = 3'd2;
    localparam logic [2:0] SRC_ST = 3'd3;
    localparam logic [2:0] SRC_BT = 3'd4;
    localparam logic [2:0] SRC_UT = 3'd5;
    localparam logic [2:0] SRC_JT = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // One stored bundle: passthrough fields plus decoded results.
    typedef struct packed {
        logic [LANES-1:0]      lv;
        logic [LANES*32-1:0]   instr;
        logic [LANES*3-1:0]    src;
        logic [LANES*XLEN-1:0] imm;
        logic [LANES-1:0]      ill;
    } entry_t;

    // Map an opcode to its immediate format; the RV64 word opcodes only
    // decode when the stage is built for a 64-bit datapath.
    function automatic logic [2:0] classify(input logic [6:0] opc);
        logic [2:0] src;
        src = SRC_NO;
        case (opc)
            7'b0110011:                                 src = SRC_RT;
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011:                     src = SRC_IT;
            7'b0100011:                                 src = SRC_ST;
            7'b1100011:                                 src = SRC_BT;
            7'b1101111:                                 src = SRC_JT;
            7'b0010111, 7'b0110111:                     src = SRC_UT;
            7'b0011011:                                 src = (XLEN == 64) ? SRC_IT : SRC_NO;
            7'b0111011:                                 src = (XLEN == 64) ? SRC_RT : SRC_NO;
            default:                                    src = SRC_NO;
        endcase
        return src;
    endfunction

    // Assemble the 32-bit immediate for a format, then sign-extend to XLEN.
    function automatic logic [XLEN-1:0] build_imm(input logic [2:0] src,
                                                  input logic [31:7] ins);
        logic [31:0] imm32;
        imm32 = 32'd0;
        case (src)
            SRC_IT:  imm32 = {{20{ins[31]}}, ins[31:20]};
            SRC_ST:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            SRC_BT:  imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            SRC_UT:  imm32 = {ins[31:12], 12'd0};
            SRC_JT:  imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        return XLEN'($signed(imm32));
    endfunction

    entry_t     dec_s;
    entry_t     out_r;
    entry_t     skid_r;
    buf_state_e state_r;
    buf_state_e state_n;
    logic       valid_r;
    logic       ready_r;
    logic       acc_s;
    logic       drn_s;
    logic       ld_out_dec_s;
    logic       ld_out_skid_s;
    logic       ld_skid_s;

    // Decode every lane of the incoming bundle; invalid lanes are decoded
    // too but never reported illegal.
    always_comb begin
        dec_s       = '0;
        dec_s.lv    = i_lane_valid;
        dec_s.instr = i_instr;
        for (int k = 0; k < LANES; k++) begin
            dec_s.src[3*k +: 3]       = classify(i_instr[32*k +: 7]);
            dec_s.imm[XLEN*k +: XLEN] = build_imm(dec_s.src[3*k +: 3], i_instr[32*k+7 +: 25]);
            dec_s.ill[k]              = i_lane_valid[k] & (dec_s.src[3*k +: 3] == SRC_NO);
        end
    end

    // Skid-buffer next-state and load enables.
    always_comb begin
        acc_s         = i_valid & ready_r;
        drn_s         = valid_r & i_ready;
        state_n       = state_r;
        ld_out_dec_s  = 1'b0;
        ld_out_skid_s = 1'b0;
        ld_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (acc_s) begin
                    state_n      = ST_ONE;
                    ld_out_dec_s = 1'b1;
                end else begin
                    state_n = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (acc_s && !drn_s) begin
                    state_n   = ST_TWO;
                    ld_skid_s = 1'b1;
                end else if (acc_s && drn_s) begin
                    state_n      = ST_ONE;
                    ld_out_dec_s = 1'b1;
                end else if (drn_s) begin
                    state_n = ST_EMPTY;
                end else begin
                    state_n = ST_ONE;
                end
            end
            ST_TWO: begin
                // o_ready is low here, so only a drain can happen.
                if (drn_s) begin
                    state_n       = ST_ONE;
                    ld_out_skid_s = 1'b1;
                end else begin
                    state_n = ST_TWO;
                end
            end
            default: begin
                state_n = ST_EMPTY;
            end
        endcase
    end

    // State, handshake and storage registers; flush shares the reset path so
    // it overrides any same-cycle accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            out_r   <= '0;
            skid_r  <= '0;
        end else begin
            state_r <= state_n;
            valid_r <= (state_n != ST_EMPTY);
            ready_r <= (state_n != ST_TWO);
            if (ld_out_dec_s) begin
                out_r <= dec_s;
            end else if (ld_out_skid_s) begin
                out_r <= skid_r;
            end else begin
                out_r <= out_r;
            end
            if (ld_skid_s) begin
                skid_r <= dec_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign o_valid      = valid_r;
    assign o_ready      = ready_r;
    assign o_lane_valid = out_r.lv;
    assign o_instr      = out_r.instr;
    assign o_imm_src    = out_r.src;
    assign o_imm        = out_r.imm;
    assign o_illegal    = out_r.ill;

endmodule
